// File: rtl/div_operand_reader_pkg.sv
// Shared constants for the FIFO read-side operand reader: state encoding
// and the default data/counter widths agreed with the word FIFO.
package div_operand_reader_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int PAIR_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    FETCH_A = 2'd0,
    FETCH_B = 2'd1,
    ISSUE   = 2'd2
  } state_t;

endpackage

// File: rtl/div_operand_reader.sv
// Pops words from the 32-bit word FIFO in pairs (dividend, then divisor) and
// offers each pair to the divider over valid/ready, holding it until accepted.
// On acceptance with more data waiting, the next dividend is fetched in the
// same edge so back-to-back pairs flow at one pair every two cycles.
module div_operand_reader
  import div_operand_reader_pkg::*;
#(
  parameter int width = DATA_WIDTH,
  parameter int cntw  = PAIR_CNT_WIDTH
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [width-1:0] Q,
  input  logic             EMPTY,
  output logic             RD,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [width-1:0] DIVIDEND,
  output logic [width-1:0] DIVISOR,
  output logic             DIVZ,
  output logic             BUSY,
  output logic [cntw-1:0]  PAIRS
);

  state_t             state_r;
  state_t             state_next_s;
  logic               load_a_s;
  logic               load_b_s;
  logic               accept_s;
  logic               pop_s;

  logic               rd_r;
  logic               valid_r;
  logic               busy_r;
  logic [width-1:0]   dividend_r;
  logic [width-1:0]   divisor_r;
  logic               divz_r;
  logic [cntw-1:0]    pairs_r;

  // A word is popped exactly when it is captured into the pair register.
  assign pop_s = load_a_s | load_b_s;

  // Next-state and capture decisions; OUT_READY only matters in ISSUE.
  always_comb begin
    state_next_s = state_r;
    load_a_s     = 1'b0;
    load_b_s     = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      FETCH_A: begin
        if (!EMPTY) begin
          load_a_s     = 1'b1;
          state_next_s = FETCH_B;
        end else begin
          state_next_s = FETCH_A;
        end
      end
      FETCH_B: begin
        if (!EMPTY) begin
          load_b_s     = 1'b1;
          state_next_s = ISSUE;
        end else begin
          state_next_s = FETCH_B;
        end
      end
      ISSUE: begin
        if (OUT_READY) begin
          accept_s = 1'b1;
          if (!EMPTY) begin
            load_a_s     = 1'b1;
            state_next_s = FETCH_B;
          end else begin
            state_next_s = FETCH_A;
          end
        end else begin
          state_next_s = ISSUE;
        end
      end
      default: begin
        state_next_s = FETCH_A;
      end
    endcase
  end

  // State register; an async reset discards any partially fetched pair.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= FETCH_A;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_r    <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      rd_r    <= pop_s;
      valid_r <= (state_next_s == ISSUE);
      busy_r  <= (state_next_s != FETCH_A);
    end
  end

  // Pair register: dividend and divisor/zero-flag captured straight from Q.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dividend_r <= {width{1'b0}};
      divisor_r  <= {width{1'b0}};
      divz_r     <= 1'b0;
    end else begin
      if (load_a_s) begin
        dividend_r <= Q;
      end
      if (load_b_s) begin
        divisor_r <= Q;
        divz_r    <= (Q == {width{1'b0}});
      end
    end
  end

  // Accepted-pair counter, wrapping naturally at 2^cntw.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pairs_r <= {cntw{1'b0}};
    end else if (accept_s) begin
      pairs_r <= pairs_r + {{(cntw-1){1'b0}}, 1'b1};
    end
  end

  assign RD        = rd_r;
  assign OUT_VALID = valid_r;
  assign BUSY      = busy_r;
  assign DIVIDEND  = dividend_r;
  assign DIVISOR   = divisor_r;
  assign DIVZ      = divz_r;
  assign PAIRS     = pairs_r;

endmodule

// File: tb/tb_div_operand_reader.sv
// Bench for div_operand_reader: a behavioural FIFO (pops on the falling edge
// when RD is high), a handshake monitor, and a word-order reference model.
// The pair counter is built 8 bits wide so the wrap can be reached quickly.
module tb_div_operand_reader;

  localparam int W  = 32;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [W-1:0]  Q = '0;
  logic          EMPTY = 1'b1;
  logic          RD;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [W-1:0]  DIVIDEND;
  logic [W-1:0]  DIVISOR;
  logic          DIVZ;
  logic          BUSY;
  logic [CW-1:0] PAIRS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         z;
    int           cyc;
  } obs_t;

  obs_t          obs[$];
  logic [W-1:0]  fifo[$];
  logic [W-1:0]  pend[$];
  logic [W-1:0]  expw[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rd_cnt = 0;
  int            ov_cnt = 0;
  int            total = 0;
  logic [CW-1:0] pairs_model = '0;

  div_operand_reader #(.width(W), .cntw(CW)) dut (
    .CLK(CLK), .nRST(nRST), .Q(Q), .EMPTY(EMPTY), .RD(RD),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DIVIDEND(DIVIDEND),
    .DIVISOR(DIVISOR), .DIVZ(DIVZ), .BUSY(BUSY), .PAIRS(PAIRS)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Behavioural word FIFO: pops on the falling edge, then accepts new writes.
  always @(negedge CLK or negedge nRST) begin
    if (!nRST) begin
      fifo.delete();
      pend.delete();
    end else begin
      if (RD && fifo.size() > 0) void'(fifo.pop_front());
      while (pend.size() > 0) fifo.push_back(pend.pop_front());
    end
    EMPTY = (fifo.size() == 0);
    Q     = (fifo.size() > 0) ? fifo[0] : '0;
  end

  // Handshake monitor: inputs change just after rising edges, so the
  // falling-edge values are those the DUT will see at the next rising edge.
  always @(negedge CLK) begin : mon
    obs_t o;
    if (nRST) begin
      if (RD) rd_cnt++;
      if (OUT_VALID) ov_cnt++;
      if (OUT_VALID && OUT_READY) begin
        o.a = DIVIDEND; o.b = DIVISOR; o.z = DIVZ; o.cyc = cyc;
        obs.push_back(o);
        total++;
        pairs_model = pairs_model + 8'd1;
      end
    end
  end

  task automatic push(input logic [W-1:0] w);
    pend.push_back(w);
    expw.push_back(w);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (i < budget && !ok) begin
      @(negedge CLK);
      if (obs.size() >= n) ok = 1'b1;
      i++;
    end
    @(negedge CLK);
  endtask

  task automatic take_pair(output obs_t o, output logic [W-1:0] ea, output logic [W-1:0] eb);
    o = obs.pop_front();
    ea = (expw.size() > 0) ? expw.pop_front() : 'x;
    eb = (expw.size() > 0) ? expw.pop_front() : 'x;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    OUT_READY = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (RD !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", RD); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", OUT_VALID); end
    checks++; if (DIVIDEND !== 32'd0) begin errors++; $display("FAIL reset_dividend got %h exp 0", DIVIDEND); end
    checks++; if (DIVISOR !== 32'd0) begin errors++; $display("FAIL reset_divisor got %h exp 0", DIVISOR); end
    checks++; if (DIVZ !== 1'b0) begin errors++; $display("FAIL reset_divz got %b exp 0", DIVZ); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (PAIRS !== 8'd0) begin errors++; $display("FAIL reset_pairs got %0d exp 0", PAIRS); end
    #2 nRST = 1'b1;
    total = 0;
    pairs_model = '0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic();
    int rd0, ov0;
    bit ok;
    obs_t o;
    logic [W-1:0] ea, eb;
    rd0 = rd_cnt; ov0 = ov_cnt;
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    push(32'd100); push(32'd7);
    wait_obs(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d pairs exp 1", obs.size()); end
    if (obs.size() > 0) begin
      take_pair(o, ea, eb);
      checks++; if (o.a !== 32'd100 || o.b !== 32'd7 || o.z !== 1'b0)
        begin errors++; $display("FAIL basic_pair got %0d/%0d/%b exp 100/7/0", o.a, o.b, o.z); end
    end
    repeat (2) @(negedge CLK);
    checks++; if (rd_cnt - rd0 !== 2) begin errors++; $display("FAIL basic_rd_pulses got %0d exp 2", rd_cnt - rd0); end
    checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d exp 1", ov_cnt - ov0); end
    checks++; if (PAIRS !== 8'd1) begin errors++; $display("FAIL basic_pairs got %0d exp 1", PAIRS); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", EMPTY); end
  endtask

  task automatic test_divz();
    bit ok;
    obs_t o;
    logic [W-1:0] ea, eb;
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    push(32'd5); push(32'd0);
    wait_obs(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL divz_timeout got %0d pairs exp 1", obs.size()); end
    if (obs.size() > 0) begin
      take_pair(o, ea, eb);
      checks++; if (o.a !== 32'd5 || o.b !== 32'd0 || o.z !== 1'b1)
        begin errors++; $display("FAIL divz_pair got %0d/%0d/%b exp 5/0/1", o.a, o.b, o.z); end
    end
  endtask

  task automatic test_stall_b();
    bit ok, seen;
    int bad;
    obs_t o;
    logic [W-1:0] ea, eb;
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    push(32'd8);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (RD) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_first_rd got 0 exp 1"); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (BUSY !== 1'b1 || RD !== 1'b0 || OUT_VALID !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_idle got %0d bad cycles exp 0", bad); end
    @(posedge CLK); #1;
    push(32'd2);
    wait_obs(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got %0d pairs exp 1", obs.size()); end
    if (obs.size() > 0) begin
      take_pair(o, ea, eb);
      checks++; if (o.a !== 32'd8 || o.b !== 32'd2 || o.z !== 1'b0)
        begin errors++; $display("FAIL stall_pair got %0d/%0d/%b exp 8/2/0", o.a, o.b, o.z); end
    end
  endtask

  task automatic test_hold();
    bit ok, seen;
    int bad, t0;
    obs_t o;
    logic [W-1:0] ea, eb;
    t0 = total;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    for (int i = 1; i <= 6; i++) push(W'(i));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (OUT_VALID) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL hold_valid got 0 exp 1"); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (OUT_VALID !== 1'b1 || DIVIDEND !== 32'd1 || DIVISOR !== 32'd2 || RD !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles exp 0", bad); end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    wait_obs(3, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got %0d pairs exp 3", obs.size()); end
    if (obs.size() >= 3) begin
      checks++; if (obs[1].cyc - obs[0].cyc != 2 || obs[2].cyc - obs[1].cyc != 2)
        begin errors++; $display("FAIL hold_spacing got %0d,%0d exp 2,2", obs[1].cyc - obs[0].cyc, obs[2].cyc - obs[1].cyc); end
    end
    while (obs.size() > 0) begin
      take_pair(o, ea, eb);
      checks++; if (o.a !== ea || o.b !== eb || o.z !== (eb == 0))
        begin errors++; $display("FAIL hold_pair got %0d/%0d/%b exp %0d/%0d/%b", o.a, o.b, o.z, ea, eb, eb == 0); end
    end
    checks++; if (total - t0 != 3) begin errors++; $display("FAIL hold_count got %0d exp 3", total - t0); end
    checks++; if (PAIRS !== pairs_model) begin errors++; $display("FAIL hold_pairs got %0d exp %0d", PAIRS, pairs_model); end
  endtask

  task automatic test_random();
    bit ok;
    int pushed, rd0;
    obs_t o;
    logic [W-1:0] ea, eb, w;
    rd0 = rd_cnt;
    pushed = 0;
    while (pushed < 60) begin
      @(posedge CLK); #1;
      OUT_READY = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        w = $urandom();
        if ($urandom_range(0, 3) == 0) w = '0;
        push(w);
        pushed++;
      end
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    wait_obs(30, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL random_timeout got %0d pairs exp 30", obs.size()); end
    while (obs.size() > 0) begin
      take_pair(o, ea, eb);
      checks++; if (o.a !== ea || o.b !== eb || o.z !== (eb == 0))
        begin errors++; $display("FAIL random_pair got %h/%h/%b exp %h/%h/%b", o.a, o.b, o.z, ea, eb, eb == 0); end
    end
    checks++; if (rd_cnt - rd0 != 60) begin errors++; $display("FAIL random_rd_count got %0d exp 60", rd_cnt - rd0); end
    checks++; if (PAIRS !== pairs_model) begin errors++; $display("FAIL random_pairs got %0d exp %0d", PAIRS, pairs_model); end
  endtask

  task automatic test_async_reset();
    bit seen;
    int obs0;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    push(32'd11); push(32'd22); push(32'd33);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (RD) seen = 1'b1;
    end
    checks++; if (!seen || BUSY !== 1'b1 || OUT_VALID !== 1'b0 || DIVIDEND !== 32'd11)
      begin errors++; $display("FAIL areset_in_fetch_b got rd=%b busy=%b valid=%b dvd=%0d exp 1/1/0/11", seen, BUSY, OUT_VALID, DIVIDEND); end
    #2 nRST = 1'b0;
    #1;
    checks++; if (RD !== 1'b0 || OUT_VALID !== 1'b0 || DIVIDEND !== 32'd0 || DIVISOR !== 32'd0 ||
                  DIVZ !== 1'b0 || BUSY !== 1'b0 || PAIRS !== 8'd0)
      begin errors++; $display("FAIL areset_outputs got rd=%b v=%b dvd=%h dvs=%h z=%b busy=%b pairs=%0d exp all 0",
                               RD, OUT_VALID, DIVIDEND, DIVISOR, DIVZ, BUSY, PAIRS); end
    expw.delete();
    total = 0;
    pairs_model = '0;
    obs0 = obs.size();
    repeat (2) @(negedge CLK);
    #2 nRST = 1'b1;
    OUT_READY = 1'b1;
    repeat (6) @(negedge CLK);
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL areset_fifo_empty got %b exp 1", EMPTY); end
    checks++; if (obs.size() != obs0 || BUSY !== 1'b0 || OUT_VALID !== 1'b0)
      begin errors++; $display("FAIL areset_no_issue got pairs=%0d busy=%b valid=%b exp %0d/0/0", obs.size(), BUSY, OUT_VALID, obs0); end
  endtask

  task automatic test_wrap();
    bit ok;
    int need;
    obs_t o;
    logic [W-1:0] ea, eb;
    need = 257 - total;
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    for (int i = 0; i < 2 * need; i++) push($urandom());
    wait_obs(need, 4 * need + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got %0d pairs exp %0d", obs.size(), need); end
    while (obs.size() > 0) begin
      take_pair(o, ea, eb);
      checks++; if (o.a !== ea || o.b !== eb || o.z !== (eb == 0))
        begin errors++; $display("FAIL wrap_pair got %h/%h/%b exp %h/%h/%b", o.a, o.b, o.z, ea, eb, eb == 0); end
    end
    checks++; if (total != 257) begin errors++; $display("FAIL wrap_total got %0d exp 257", total); end
    checks++; if (PAIRS !== 8'd1) begin errors++; $display("FAIL wrap_pairs got %0d exp 1", PAIRS); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divz();
    test_stall_b();
    test_hold();
    test_random();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
